// File: rtl/fpu_addsub_special_pipe_if.sv
// ---------------------------------------------------------------------------
// fpu_addsub_special_pipe_if
// Handshake/bus bundle for the FP add/sub special-case unit.
//   master : operand source + result sink (drives i_*, observes o_*)
//   slave  : the special-case unit (observes i_*, drives o_*)
// Signals:
//   i_valid/o_ready          operand handshake
//   i_sub, i_sign_*, i_exp_*, i_man_*, i_tag   operation and operands
//   i_clr_flags              clear the sticky invalid flag
//   o_valid/i_ready          result handshake
//   o_sel_exp, o_sel_man, o_sign, o_is_special, o_invalid, o_sticky_inv, o_tag
// ---------------------------------------------------------------------------
interface fpu_addsub_special_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
);
    logic              i_valid;
    logic              o_ready;
    logic              i_sub;
    logic              i_sign_a;
    logic              i_sign_b;
    logic [EXP_W-1:0]  i_exp_a;
    logic [EXP_W-1:0]  i_exp_b;
    logic [FRAC_W:0]   i_man_a;
    logic [FRAC_W:0]   i_man_b;
    logic [TAG_W-1:0]  i_tag;
    logic              i_clr_flags;
    logic              o_valid;
    logic              i_ready;
    logic [1:0]        o_sel_exp;
    logic [1:0]        o_sel_man;
    logic              o_sign;
    logic              o_is_special;
    logic              o_invalid;
    logic              o_sticky_inv;
    logic [TAG_W-1:0]  o_tag;

    modport master (
        output i_valid, i_sub, i_sign_a, i_sign_b, i_exp_a, i_exp_b,
               i_man_a, i_man_b, i_tag, i_clr_flags, i_ready,
        input  o_ready, o_valid, o_sel_exp, o_sel_man, o_sign,
               o_is_special, o_invalid, o_sticky_inv, o_tag
    );

    modport slave (
        input  i_valid, i_sub, i_sign_a, i_sign_b, i_exp_a, i_exp_b,
               i_man_a, i_man_b, i_tag, i_clr_flags, i_ready,
        output o_ready, o_valid, o_sel_exp, o_sel_man, o_sign,
               o_is_special, o_invalid, o_sticky_inv, o_tag
    );
endinterface

// File: rtl/fpu_addsub_special_pipe.sv
// ---------------------------------------------------------------------------
// fpu_addsub_special_pipe
// Two-stage special-case / path-select unit for the FP add/sub datapath.
// Stage 1 classifies both operands and compares them; stage 2 decodes the
// result-select codes, result sign and IEEE invalid flag.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous reset, active low
//   bus      fpu_addsub_special_pipe_if.slave (operand/result handshakes)
// Select codes: 00 datapath, 01 all-ones / quiet NaN, 10 all-zeros.
// Configuration: define FPU_PSC_FTZ_EN to treat subnormal operands as zero.
// ---------------------------------------------------------------------------
module fpu_addsub_special_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    fpu_addsub_special_pipe_if.slave bus
);
    localparam logic [1:0] SEL_DP   = 2'b00;
    localparam logic [1:0] SEL_ONES = 2'b01;
    localparam logic [1:0] SEL_ZERO = 2'b10;

    // Operand classification (hidden bit ignored)
    logic [FRAC_W-1:0] frac_a, frac_b;
    logic exp_max_a, exp_max_b, exp_zero_a, exp_zero_b;
    logic frac_zero_a, frac_zero_b;
    logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;
    logic unused_hidden;

    assign frac_a      = bus.i_man_a[FRAC_W-1:0];
    assign frac_b      = bus.i_man_b[FRAC_W-1:0];
    assign exp_max_a   = &bus.i_exp_a;
    assign exp_max_b   = &bus.i_exp_b;
    assign exp_zero_a  = ~|bus.i_exp_a;
    assign exp_zero_b  = ~|bus.i_exp_b;
    assign frac_zero_a = ~|frac_a;
    assign frac_zero_b = ~|frac_b;
    assign inf_a       = exp_max_a & frac_zero_a;
    assign inf_b       = exp_max_b & frac_zero_b;
    assign nan_a       = exp_max_a & ~frac_zero_a;
    assign nan_b       = exp_max_b & ~frac_zero_b;
    assign snan_a      = nan_a & ~frac_a[FRAC_W-1];
    assign snan_b      = nan_b & ~frac_b[FRAC_W-1];
    assign unused_hidden = bus.i_man_a[FRAC_W] ^ bus.i_man_b[FRAC_W];

`ifdef FPU_PSC_FTZ_EN
    // Flush-to-zero: any exponent-0 operand is in the zero class
    assign zero_a = exp_zero_a;
    assign zero_b = exp_zero_b;
`else
    assign zero_a = exp_zero_a & frac_zero_a;
    assign zero_b = exp_zero_b & frac_zero_b;
`endif

    // Pipeline state
    logic             rdy_en;
    logic             s1_valid, s2_valid;
    logic             s2_adv;
    logic             s1_sa, s1_sb, s1_exp_eq, s1_frac_eq;
    logic             s1_zero_a, s1_zero_b, s1_inf_a, s1_inf_b;
    logic             s1_nan_a, s1_nan_b, s1_snan_a, s1_snan_b;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [1:0]       s2_sel_exp, s2_sel_man;
    logic             s2_sign, s2_special, s2_invalid, sticky;

    // Stage 2 drains when empty or accepted downstream; stage 1 refills when
    // empty or moving into stage 2. rdy_en keeps o_ready low until the first
    // clock after reset release.
    assign s2_adv      = ~s2_valid | bus.i_ready;
    assign bus.o_ready = rdy_en & (~s1_valid | s2_adv);

    // Stage 2 decode
    logic [1:0] d_sel_exp, d_sel_man;
    logic       d_sign, d_special, d_invalid, inf_inf;

    always_comb begin
        d_sel_exp = SEL_DP;
        d_sel_man = SEL_DP;
        d_sign    = 1'b0;
        d_special = 1'b0;
        d_invalid = 1'b0;
        inf_inf   = s1_inf_a & s1_inf_b & (s1_sa ^ s1_sb);
        if (s1_nan_a | s1_nan_b | inf_inf) begin
            d_sel_exp = SEL_ONES;
            d_sel_man = SEL_ONES;
            d_special = 1'b1;
            d_invalid = s1_snan_a | s1_snan_b | inf_inf;
        end else if (s1_inf_a | s1_inf_b) begin
            d_sel_exp = SEL_ONES;
            d_sel_man = SEL_ZERO;
            d_special = 1'b1;
            d_sign    = s1_inf_a ? s1_sa : s1_sb;
        end else if (s1_zero_a & s1_zero_b) begin
            d_sel_exp = SEL_ZERO;
            d_sel_man = SEL_ZERO;
            d_special = 1'b1;
            d_sign    = s1_sa & s1_sb;
        end else if ((s1_sa ^ s1_sb) & s1_exp_eq & s1_frac_eq) begin
            d_sel_exp = SEL_ZERO;
            d_sel_man = SEL_ZERO;
            d_special = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_sa      <= 1'b0;
            s1_sb      <= 1'b0;
            s1_exp_eq  <= 1'b0;
            s1_frac_eq <= 1'b0;
            s1_zero_a  <= 1'b0;
            s1_zero_b  <= 1'b0;
            s1_inf_a   <= 1'b0;
            s1_inf_b   <= 1'b0;
            s1_nan_a   <= 1'b0;
            s1_nan_b   <= 1'b0;
            s1_snan_a  <= 1'b0;
            s1_snan_b  <= 1'b0;
            s1_tag     <= '0;
            s2_valid   <= 1'b0;
            s2_sel_exp <= '0;
            s2_sel_man <= '0;
            s2_sign    <= 1'b0;
            s2_special <= 1'b0;
            s2_invalid <= 1'b0;
            s2_tag     <= '0;
            sticky     <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (bus.o_ready) begin
                s1_valid <= bus.i_valid;
                if (bus.i_valid) begin
                    s1_sa      <= bus.i_sign_a;
                    s1_sb      <= bus.i_sign_b ^ bus.i_sub;
                    s1_exp_eq  <= (bus.i_exp_a == bus.i_exp_b);
                    s1_frac_eq <= (frac_a == frac_b);
                    s1_zero_a  <= zero_a;
                    s1_zero_b  <= zero_b;
                    s1_inf_a   <= inf_a;
                    s1_inf_b   <= inf_b;
                    s1_nan_a   <= nan_a;
                    s1_nan_b   <= nan_b;
                    s1_snan_a  <= snan_a;
                    s1_snan_b  <= snan_b;
                    s1_tag     <= bus.i_tag;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_sel_exp <= d_sel_exp;
                    s2_sel_man <= d_sel_man;
                    s2_sign    <= d_sign;
                    s2_special <= d_special;
                    s2_invalid <= d_invalid;
                    s2_tag     <= s1_tag;
                end
            end
            // Set beats clear when both happen in the same cycle
            if (s2_valid & bus.i_ready & s2_invalid)
                sticky <= 1'b1;
            else if (bus.i_clr_flags)
                sticky <= 1'b0;
        end
    end

    assign bus.o_valid      = s2_valid;
    assign bus.o_sel_exp    = s2_sel_exp;
    assign bus.o_sel_man    = s2_sel_man;
    assign bus.o_sign       = s2_sign;
    assign bus.o_is_special = s2_special;
    assign bus.o_invalid    = s2_invalid;
    assign bus.o_sticky_inv = sticky;
    assign bus.o_tag        = s2_tag;
endmodule

// File: tb/tb_fpu_addsub_special_pipe.sv
// ---------------------------------------------------------------------------
// tb_fpu_addsub_special_pipe
// Self-checking bench: directed IEEE cases, stall/back-pressure sequence,
// randomized operands against a value-level reference model, async reset
// mid-flight. Follows FPU_PSC_FTZ_EN like the design.
// ---------------------------------------------------------------------------
module tb_fpu_addsub_special_pipe;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int TAG_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_addsub_special_pipe_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) bus ();

    fpu_addsub_special_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef enum int {K_ZERO, K_FIN, K_INF, K_QNAN, K_SNAN} kind_t;
    typedef enum int {R_DP, R_NAN, R_INF, R_ZERO} res_t;

    typedef struct {
        logic [1:0]       se;
        logic [1:0]       sm;
        logic             sg;
        logic             sp;
        logic             inv;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic sticky_m = 1'b0;
    logic last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic kind_t classify(input logic [EXP_W-1:0] e, input logic [FRAC_W:0] m);
        logic [FRAC_W-1:0] f;
        f = m[FRAC_W-1:0];
        if (e == 0) begin
`ifdef FPU_PSC_FTZ_EN
            return K_ZERO;
`else
            return (f == 0) ? K_ZERO : K_FIN;
`endif
        end
        if (e == {EXP_W{1'b1}}) begin
            if (f == 0) return K_INF;
            return f[FRAC_W-1] ? K_QNAN : K_SNAN;
        end
        return K_FIN;
    endfunction

    // IEEE-level outcome of a +/- b, then mapped onto the select codes
    function automatic exp_t model(input logic sub, input logic sa, input logic [EXP_W-1:0] ea,
                                   input logic [FRAC_W:0] ma, input logic sbr,
                                   input logic [EXP_W-1:0] eb, input logic [FRAC_W:0] mb,
                                   input logic [TAG_W-1:0] tag);
        exp_t  r;
        kind_t ka, kb;
        res_t  res;
        logic  sb, sgn, inv;
        ka  = classify(ea, ma);
        kb  = classify(eb, mb);
        sb  = sbr ^ sub;
        sgn = 1'b0;
        inv = 1'b0;
        if (ka == K_QNAN || ka == K_SNAN || kb == K_QNAN || kb == K_SNAN) begin
            res = R_NAN;
            inv = (ka == K_SNAN) || (kb == K_SNAN);
        end else if (ka == K_INF && kb == K_INF && sa != sb) begin
            res = R_NAN;
            inv = 1'b1;
        end else if (ka == K_INF) begin
            res = R_INF; sgn = sa;
        end else if (kb == K_INF) begin
            res = R_INF; sgn = sb;
        end else if (ka == K_ZERO && kb == K_ZERO) begin
            res = R_ZERO; sgn = sa & sb;
        end else if (sa != sb && ea == eb && ma[FRAC_W-1:0] == mb[FRAC_W-1:0]) begin
            res = R_ZERO;            // x + (-x) rounds to +0
        end else begin
            res = R_DP;
        end
        case (res)
            R_NAN:   begin r.se = 2'b01; r.sm = 2'b01; r.sp = 1'b1; r.sg = 1'b0; end
            R_INF:   begin r.se = 2'b01; r.sm = 2'b10; r.sp = 1'b1; r.sg = sgn;  end
            R_ZERO:  begin r.se = 2'b10; r.sm = 2'b10; r.sp = 1'b1; r.sg = sgn;  end
            default: begin r.se = 2'b00; r.sm = 2'b00; r.sp = 1'b0; r.sg = 1'b0; end
        endcase
        r.inv = inv;
        r.tag = tag;
        r.acc = cyc;
        return r;
    endfunction

    task automatic set_op(input logic v, input logic sub, input logic sa, input logic [EXP_W-1:0] ea,
                          input logic [FRAC_W-1:0] fa, input logic sb, input logic [EXP_W-1:0] eb,
                          input logic [FRAC_W-1:0] fb, input logic [TAG_W-1:0] tag);
        bus.i_valid  = v;
        bus.i_sub    = sub;
        bus.i_sign_a = sa;
        bus.i_exp_a  = ea;
        bus.i_man_a  = {(ea != 0), fa};
        bus.i_sign_b = sb;
        bus.i_exp_b  = eb;
        bus.i_man_b  = {(eb != 0), fb};
        bus.i_tag    = tag;
    endtask

    task automatic rand_operand(output logic s, output logic [EXP_W-1:0] e, output logic [FRAC_W-1:0] f);
        s = 1'($urandom_range(0, 1));
        f = FRAC_W'($urandom);
        case ($urandom_range(0, 7))
            0: begin e = '0; f = '0; end
            1: begin e = '0; f = f | 1; end
            2: begin e = '1; f = '0; end
            3: begin e = '1; f[FRAC_W-1] = 1'b1; end
            4: begin e = '1; f[FRAC_W-1] = 1'b0; f = f | 1; end
            default: e = EXP_W'($urandom_range(1, 254));
        endcase
    endtask

    // One clock: check outputs mid-cycle, then account for the edge's transfers
    task automatic step();
        exp_t h;
        logic acc, drn, ev;
        #1;
        ev = (q.size() > 0) && (cyc - q[0].acc >= 2);
        chk("o_valid", 32'(bus.o_valid), 32'(ev));
        chk("o_ready", 32'(bus.o_ready), 32'(!(q.size() == 2 && !bus.i_ready)));
        chk("o_sticky_inv", 32'(bus.o_sticky_inv), 32'(sticky_m));
        if (bus.o_valid && q.size() > 0) begin
            chk("o_sel_exp", 32'(bus.o_sel_exp), 32'(q[0].se));
            chk("o_sel_man", 32'(bus.o_sel_man), 32'(q[0].sm));
            chk("o_sign", 32'(bus.o_sign), 32'(q[0].sg));
            chk("o_is_special", 32'(bus.o_is_special), 32'(q[0].sp));
            chk("o_invalid", 32'(bus.o_invalid), 32'(q[0].inv));
            chk("o_tag", 32'(bus.o_tag), 32'(q[0].tag));
        end
        acc = bus.i_valid & bus.o_ready;
        drn = bus.o_valid & bus.i_ready;
        if (acc)
            h = model(bus.i_sub, bus.i_sign_a, bus.i_exp_a, bus.i_man_a,
                      bus.i_sign_b, bus.i_exp_b, bus.i_man_b, bus.i_tag);
        @(posedge clk);
        if (drn && q.size() > 0 && q[0].inv) sticky_m = 1'b1;
        else if (bus.i_clr_flags)            sticky_m = 1'b0;
        if (drn && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(h);
        last_acc = acc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk(tag, 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic             sa, sb;
        logic [EXP_W-1:0]  ea, eb;
        logic [FRAC_W-1:0] fa, fb;
        int sent;

        set_op(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        bus.i_clr_flags = 1'b0;
        bus.i_ready     = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_ready", 32'(bus.o_ready), 32'd0);
        chk("rst_sel", {28'd0, bus.o_sel_exp, bus.o_sel_man}, 32'd0);
        chk("rst_flags", {29'd0, bus.o_invalid, bus.o_sticky_inv, bus.o_is_special}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Directed cases, one op then idle (latency 2 checked through o_valid)
        set_op(1, 0, 0, 8'd127, 23'h0, 0, 8'd127, 23'h0, 4'd3); step(); bus.i_valid = 0; step(); step();
        set_op(1, 1, 0, 8'hFF, 23'h0, 0, 8'hFF, 23'h0, 4'd4); step(); bus.i_valid = 0; step(); step(); step();
        bus.i_clr_flags = 1'b1; step(); bus.i_clr_flags = 1'b0; step();
        set_op(1, 0, 0, 8'hFF, 23'h000001, 0, 8'd127, 23'h0, 4'd5); step(); bus.i_valid = 0; step(); step();
        set_op(1, 0, 0, 8'hFF, 23'h400000, 0, 8'd127, 23'h0, 4'd6); step(); bus.i_valid = 0; step(); step();
        set_op(1, 0, 1, 8'h00, 23'h0, 1, 8'h00, 23'h0, 4'd7); step(); bus.i_valid = 0; step(); step();
        set_op(1, 1, 0, 8'd128, 23'h400000, 0, 8'd128, 23'h400000, 4'd8); step(); bus.i_valid = 0; step(); step();
        set_op(1, 0, 1, 8'hFF, 23'h0, 0, 8'd129, 23'h200000, 4'd9); step(); bus.i_valid = 0; step(); step();
        set_op(1, 0, 0, 8'h00, 23'h000010, 0, 8'h00, 23'h0, 4'd10); step(); bus.i_valid = 0; step(); step();
        bus.i_clr_flags = 1'b1; step(); bus.i_clr_flags = 1'b0;
        drain("directed_drain");

        // 8 back-to-back ops with i_ready toggling every cycle
        sent = 0;
        last_acc = 1'b1;
        for (int i = 0; i < 60 && (sent < 8 || q.size() > 0); i++) begin
            if (last_acc) begin
                if (sent < 8) begin
                    rand_operand(sa, ea, fa);
                    rand_operand(sb, eb, fb);
                    set_op(1, 1'($urandom_range(0, 1)), sa, ea, fa, sb, eb, fb, TAG_W'(sent));
                end else begin
                    bus.i_valid = 1'b0;
                end
            end
            bus.i_ready = i[0];
            step();
            if (last_acc) sent++;
        end
        chk("stall_sent", 32'(sent), 32'd8);
        drain("stall_drain");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_operand(sa, ea, fa);
            rand_operand(sb, eb, fb);
            if ($urandom_range(0, 3) == 0) begin sb = sa; eb = ea; fb = fa; end
            set_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   sa, ea, fa, sb, eb, fb, TAG_W'($urandom));
            bus.i_ready     = 1'($urandom_range(0, 3) != 0);
            bus.i_clr_flags = ($urandom_range(0, 15) == 0);
            step();
        end
        bus.i_clr_flags = 1'b0;
        drain("random_drain");

        // Async reset with ops in flight: they must vanish
        bus.i_ready = 1'b0;
        set_op(1, 1, 0, 8'hFF, 23'h0, 0, 8'hFF, 23'h0, 4'd1); step();
        set_op(1, 0, 0, 8'd127, 23'h0, 0, 8'd127, 23'h0, 4'd2); step();
        bus.i_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_o_ready", 32'(bus.o_ready), 32'd0);
        chk("arst_tag", 32'(bus.o_tag), 32'd0);
        q.delete();
        sticky_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_ready = 1'b1;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
